// File: rtl/sar_adc_ctrl_if.sv
// Handshake and analog-loop signals between the SAR controller and its host/AFE.
// slave is the controller side, master is the host plus comparator/DAC side.
interface sar_adc_ctrl_if #(
    parameter int WIDTH = 8
);
    logic             start;
    logic             cmp_in;
    logic             sample;
    logic [WIDTH-1:0] dac_code;
    logic             busy;
    logic             done;
    logic             valid;
    logic [WIDTH-1:0] result;

    modport slave (
        input  start,
        input  cmp_in,
        output sample,
        output dac_code,
        output busy,
        output done,
        output valid,
        output result
    );

    modport master (
        output start,
        output cmp_in,
        input  sample,
        input  dac_code,
        input  busy,
        input  done,
        input  valid,
        input  result
    );
endinterface

// File: rtl/sar_adc_ctrl.sv
// Successive-approximation controller: track/hold sequencing, MSB-first binary
// search on the reference DAC, one bit resolved every SETTLE cycles.
module sar_adc_ctrl #(
    parameter int WIDTH      = 8,
    parameter int SAMPLE_CYC = 2,
    parameter int SETTLE     = 2
) (
    input  logic          clk,
    input  logic          rst_n,
    sar_adc_ctrl_if.slave bus
);

    localparam logic [1:0] IDLE   = 2'd0;
    localparam logic [1:0] SAMPLE = 2'd1;
    localparam logic [1:0] TRIAL  = 2'd2;
    localparam logic [1:0] DONE   = 2'd3;

    localparam int CNT_MAX = (SAMPLE_CYC > SETTLE) ? SAMPLE_CYC : SETTLE;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam int IDX_W   = $clog2(WIDTH);

    logic [1:0]       state_reg,  state_next;
    logic [CNT_W-1:0] cnt_reg,    cnt_next;
    logic [IDX_W-1:0] idx_reg,    idx_next;
    logic [WIDTH-1:0] code_reg,   code_next;
    logic [WIDTH-1:0] result_reg, result_next;
    logic             sample_reg, sample_next;
    logic             busy_reg,   busy_next;
    logic             done_reg,   done_next;
    logic             valid_reg,  valid_next;

    logic [IDX_W-1:0] idx_dec;
    logic [WIDTH-1:0] decided_code;
    logic [WIDTH-1:0] next_trial_bit;

    assign idx_dec = idx_reg - IDX_W'(1);

    // decided_code: current trial with the bit under test replaced by the comparator
    // verdict; next_trial_bit: the one-hot probe for the following bit position.
    generate
        for (genvar gi = 0; gi < WIDTH; gi++) begin : g_bit
            assign decided_code[gi]   = (idx_reg == IDX_W'(gi)) ? bus.cmp_in : code_reg[gi];
            assign next_trial_bit[gi] = (idx_dec == IDX_W'(gi));
        end
    endgenerate

    always_comb begin
        state_next  = state_reg;
        cnt_next    = cnt_reg;
        idx_next    = idx_reg;
        code_next   = code_reg;
        result_next = result_reg;
        sample_next = sample_reg;
        busy_next   = busy_reg;
        done_next   = 1'b0;
        valid_next  = valid_reg;

        case (state_reg)
            IDLE: begin
                code_next   = '0;
                sample_next = 1'b0;
                if (bus.start) begin
                    state_next  = SAMPLE;
                    busy_next   = 1'b1;
                    valid_next  = 1'b0;
                    sample_next = 1'b1;
                    cnt_next    = CNT_W'(SAMPLE_CYC);
                end
            end

            SAMPLE: begin
                if (cnt_reg == CNT_W'(1)) begin
                    state_next           = TRIAL;
                    sample_next          = 1'b0;
                    idx_next             = IDX_W'(WIDTH - 1);
                    code_next            = '0;
                    code_next[WIDTH-1]   = 1'b1;
                    cnt_next             = CNT_W'(SETTLE);
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end

            TRIAL: begin
                // Decision edge: latch this bit and present the next probe on the same edge.
                if (cnt_reg == CNT_W'(1)) begin
                    if (idx_reg == '0) begin
                        state_next  = DONE;
                        code_next   = decided_code;
                        result_next = decided_code;
                        done_next   = 1'b1;
                        valid_next  = 1'b1;
                        cnt_next    = '0;
                    end else begin
                        code_next = decided_code | next_trial_bit;
                        idx_next  = idx_dec;
                        cnt_next  = CNT_W'(SETTLE);
                    end
                end else begin
                    cnt_next = cnt_reg - CNT_W'(1);
                end
            end

            DONE: begin
                state_next = IDLE;
                busy_next  = 1'b0;
                code_next  = '0;
                idx_next   = '0;
                cnt_next   = '0;
            end

            default: begin
                state_next  = IDLE;
                busy_next   = 1'b0;
                sample_next = 1'b0;
                code_next   = '0;
                idx_next    = '0;
                cnt_next    = '0;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg  <= IDLE;
            cnt_reg    <= '0;
            idx_reg    <= '0;
            code_reg   <= '0;
            result_reg <= '0;
            sample_reg <= 1'b0;
            busy_reg   <= 1'b0;
            done_reg   <= 1'b0;
            valid_reg  <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            idx_reg    <= idx_next;
            code_reg   <= code_next;
            result_reg <= result_next;
            sample_reg <= sample_next;
            busy_reg   <= busy_next;
            done_reg   <= done_next;
            valid_reg  <= valid_next;
        end
    end

    assign bus.sample   = sample_reg;
    assign bus.dac_code = code_reg;
    assign bus.busy     = busy_reg;
    assign bus.done     = done_reg;
    assign bus.valid    = valid_reg;
    assign bus.result   = result_reg;

`ifndef SYNTHESIS
    a_done_busy : assert property (@(posedge clk) disable iff (!rst_n) done_reg |-> busy_reg);
    a_done_code : assert property (@(posedge clk) disable iff (!rst_n) done_reg |-> (code_reg == result_reg));
    a_track_idle: assert property (@(posedge clk) disable iff (!rst_n) sample_reg |-> (code_reg == '0));
`endif

endmodule

// File: doc/sar_adc_ctrl.md
# sar_adc_ctrl

Successive-approximation controller that digitises the output of the differential-amplifier comparator stage. It sequences the track/hold switch and drives a binary-weighted trial code to the reference DAC feeding the amplifier's second input. It samples the amplifier output after each trial and resolves one bit per step, MSB first. It sits directly downstream of the amplifier, consuming `out1` as `cmp_in`, and closes the loop by driving `dac_code` back to the amplifier's reference input.

## Interface
- `WIDTH`, 8: result and DAC code width, 2..16.
- `SAMPLE_CYC`, 2: cycles the track/hold switch is held closed, ≥1.
- `SETTLE`, 2: cycles per bit trial from DAC update to comparator decision, ≥1.

- `clk` input 1: single clock; all state changes on its rising edge.
- `rst_n` input 1: asynchronous, active-low reset.
- `start` input 1: conversion request, level-sampled; accepted only in IDLE.
- `cmp_in` input 1: amplifier output; 1 means Vin ≥ Vdac.
- `sample` output 1: track/hold switch control, 1 = track.
- `dac_code` output WIDTH: trial code to the reference DAC.
- `busy` output 1: 1 from the accept edge until return to IDLE.
- `done` output 1: one-cycle pulse when the result is loaded.
- `valid` output 1: result holds a completed conversion.
- `result` output WIDTH: last completed conversion code.

## Operation
- States: IDLE, SAMPLE, TRIAL, DONE.
- Reset, asynchronous:
  - state = IDLE.
  - `sample` = 0, `dac_code` = 0, `busy` = 0, `done` = 0, `valid` = 0, `result` = 0.
  - Bit index and cycle counter = 0.
- IDLE:
  - `dac_code` = 0 and `sample` = 0.
  - `start` = 1 at an edge moves to SAMPLE, sets `busy` = 1, clears `valid`, and loads counter = SAMPLE_CYC.
- SAMPLE:
  - `sample` = 1 for exactly SAMPLE_CYC cycles.
  - On leaving, moves to TRIAL with bit index = WIDTH-1.
  - `dac_code` = only the MSB set (trial code); `sample` = 0.
- TRIAL:
  - Holds `dac_code` = kept bits | (1 << index) for SETTLE cycles.
  - `cmp_in` is sampled on the last edge of the period.
  - If `cmp_in` = 1 the bit is kept, otherwise it is cleared.
  - The next bit's trial code appears on the same edge.
  - After index 0 is decided, moves to DONE.
- DONE:
  - Lasts one cycle.
  - `result` = final code, `done` = 1, `valid` = 1, `dac_code` = final code.
  - The next edge returns to IDLE with `busy` = 0.
- `start` in SAMPLE, TRIAL or DONE is ignored; it is not queued.
- `cmp_in` must be stable at the decision edge; SETTLE budgets DAC and amplifier settling. There is no internal synchroniser.
- `result` and `valid` hold until the next accepted `start`. `start` clears `valid` only.
- Width rule: kept bits never change after their decision. The final code equals the largest code with cmp = 1 under a monotonic comparator.

## Timing
- Edge 0 is the edge that accepts `start`.
- `sample` = 1 after edges 0..SAMPLE_CYC-1.
- First trial code is driven after edge SAMPLE_CYC.
- Bit k (MSB = 1st) is decided at edge SAMPLE_CYC + k·SETTLE.
- `done` = 1 after edge SAMPLE_CYC + WIDTH·SETTLE (18 with defaults), for one cycle.
- Back-to-back: with `start` held high, the earliest next accept is 2 edges after `done` rises. Total period = SAMPLE_CYC + WIDTH·SETTLE + 2 = 20 cycles.
- Reset mid-conversion aborts immediately to reset values; no `done` is produced.
- All outputs are registered; no combinational path from `cmp_in` or `start` to any output.

## Test plan
- Ideal comparator model (`cmp_in` = Vin_code ≥ `dac_code`), Vin = 0xA5, pulse `start`:
  - `dac_code` sequence 0x80, 0xC0, 0xA0, 0xB0, 0xA8, 0xA4, 0xA6, 0xA5, each held 2 cycles.
  - `done` rises 18 cycles after the accept edge with `result` = 0xA5, `valid` = 1.
- Endpoints:
  - Vin = 0x00 → `result` 0x00.
  - Vin = 0xFF → `result` 0xFF, `dac_code` final 0xFF.
  - Both give exactly one `done` pulse each.
- `start` pulsed at cycles 5 and 12 after the accept edge → ignored. Single `done` at 18, `busy` high through cycle 18 and low at 19.
- `start` held high continuously with Vin = 0x3C → `done` pulses at cycles 18, 38, 58, each with `result` 0x3C. `valid` drops at each accept edge.
- `rst_n` asserted mid-conversion at cycle 9, with no clock edge needed → all outputs 0 immediately. After release, a fresh conversion of Vin = 0x5A completes with `result` 0x5A.
- `SAMPLE_CYC` = 1, `SETTLE` = 3, Vin = 0x81 → `sample` high 1 cycle, each trial held 3 cycles, `done` at cycle 25, `result` 0x81.
